sample_accumulator: RTL and testbench
=====================================

SAMPLE_ACCUMULATOR -- requirements
Module: sample_accumulator

Interface
REQ-001 SHALL have parameter WINDOW, default 16, giving the samples per window; legal range 1..65535.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port sample_valid, input, 1 bit: sample is presented.
REQ-005 SHALL have port sample, input, int (32-bit signed): input sample value.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept a sample.
REQ-007 SHALL have port flush, input, 1 bit: close the current window early.
REQ-008 SHALL have port data, output, int (32-bit signed): window sum, feeding the downstream normalizer.
REQ-009 SHALL have port norm_count, output, 16 bits: number of samples in the window; never 0 while out_valid=1.
REQ-010 SHALL have port out_valid, output, 1 bit: data and norm_count hold a completed window.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream consumes the window.
REQ-012 SHALL have port sat, output, 1 bit: the window sum saturated at least once.

Function
REQ-013 SHALL implement states IDLE (count 0), ACCUM (0 < count < WINDOW), HOLD (window closed, awaiting consumer).
REQ-014 SHALL drive in_ready=1 in IDLE and ACCUM, and 0 in HOLD; in_ready is decoded from state only.
REQ-015 SHALL accept a sample only on a cycle with sample_valid=1 and in_ready=1 (accept).
REQ-016 SHALL, on accept in IDLE, set sum=sample, count=1 and sat=0, then enter ACCUM, or HOLD if WINDOW=1.
REQ-017 SHALL, on accept in ACCUM, set sum=sum+sample and count=count+1; if the new count equals WINDOW, enter HOLD.
REQ-018 SHALL compute the sum in 33-bit signed arithmetic and clamp it to 2^31-1 or -2^31 on overflow, setting sat=1, which stays set until the window is consumed.
REQ-019 SHALL, on flush=1 in ACCUM, enter HOLD with the current count; a sample accepted in the same cycle is included first.
REQ-020 SHALL, on flush=1 in IDLE, accept any same-cycle sample into a new window (count 1) and enter HOLD; flush with no sample in IDLE SHALL be ignored, so no zero-count window is ever emitted.
REQ-021 SHALL ignore flush in HOLD.
REQ-022 SHALL drive out_valid=1 exactly while in HOLD; it rises the cycle after the closing accept or flush (latency 1 clock).
REQ-023 SHALL keep data, norm_count and sat stable while out_valid=1.
REQ-024 SHALL, on out_valid=1 with out_ready=1, return to IDLE the next cycle, with sum=0, count=0 and sat=0.
REQ-025 SHALL ignore out_ready outside HOLD.
REQ-026 SHALL drive data and norm_count from the sum and count registers in all states; they are meaningful only when out_valid=1.
REQ-027 SHALL have maximum throughput of one sample per clock, with one bubble cycle per window (HOLD with out_ready=1).

Reset
REQ-028 SHALL, while rst=0, force state to IDLE and drive data=0, norm_count=0, out_valid=0 and sat=0, independent of clk.
REQ-029 SHALL drive in_ready=1 while in reset; samples SHALL NOT be accepted until the first rising edge of clk after rst rises.
REQ-030 SHALL, on reset asserted mid-window or in HOLD, discard the partial or pending window with no out_valid pulse.

Verification
REQ-031 SHALL be verified with this scenario: WINDOW=4, samples 10,20,30,40 sent back-to-back, out_ready=1 -> out_valid for 1 cycle, data=100, norm_count=4, sat=0.
REQ-032 SHALL be verified with this scenario: WINDOW=4, samples 5,-7 then flush on the 3rd cycle with sample 2 -> data=0, norm_count=3.
REQ-033 SHALL be verified with this scenario: WINDOW=2, samples 2^31-1 and 5 -> data=2^31-1, sat=1; the next window, samples 1,1 -> data=2, sat=0.
REQ-034 SHALL be verified with this scenario: window closed with out_ready=0 for 5 cycles -> out_valid, data and norm_count held, in_ready=0, sample_valid ignored; a sample sent in the cycle after out_ready=1 is accepted.
REQ-035 SHALL be verified with this scenario: flush in IDLE with sample_valid=0 -> no state change and out_valid stays 0; WINDOW=1 with sample 9 -> data=9, norm_count=1.
REQ-036 SHALL be verified with this scenario: rst=0 asserted after 2 of 4 samples -> outputs go to 0 immediately; the next 4 samples sum with no residue.

Source files
------------

// File: rtl/sample_accumulator.sv
// Windowed sample accumulator: sums up to WINDOW signed samples with saturation,
// then holds the closed window (sum, count, sat) until the downstream consumes it.
module sample_accumulator #(
    parameter int unsigned WINDOW = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_valid,
    input  logic signed [31:0] sample,
    output logic               in_ready,
    input  logic               flush,
    output logic signed [31:0] data,
    output logic        [15:0] norm_count,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sat,
    output logic        [1:0]  state_dbg
);

    // Handshakes: a sample moves on a cycle with sample_valid=1 and in_ready=1;
    // a window moves on a cycle with out_valid=1 and out_ready=1.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [15:0] WINDOW_L = WINDOW[15:0];

    state_t             state_q, state_d;
    logic signed [31:0] sum_q, sum_d;
    logic        [15:0] count_q, count_d;
    logic               sat_q, sat_d;

    logic               accept;
    logic signed [32:0] sum_wide;
    logic               ovf;
    logic signed [31:0] sum_sat;
    logic        [15:0] count_inc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sum_q   <= '0;
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    // Overflow shows up as disagreement between the two top bits of the 33-bit sum.
    always_comb begin
        sum_wide  = {sum_q[31], sum_q} + {sample[31], sample};
        ovf       = sum_wide[32] ^ sum_wide[31];
        sum_sat   = sum_wide[31:0];
        if (ovf) begin
            sum_sat = sum_wide[32] ? 32'sh8000_0000 : 32'sh7fff_ffff;
        end
        count_inc = count_q + 16'd1;
        accept    = sample_valid && (state_q != HOLD);
    end

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        count_d = count_q;
        sat_d   = sat_q;
        case (state_q)
            IDLE: begin
                // A bare flush in IDLE is dropped so no empty window is emitted.
                if (accept) begin
                    sum_d   = sample;
                    count_d = 16'd1;
                    sat_d   = 1'b0;
                    state_d = (flush || (WINDOW_L == 16'd1)) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    sum_d   = sum_sat;
                    count_d = count_inc;
                    sat_d   = sat_q | ovf;
                end
                if (flush || (accept && (count_inc == WINDOW_L))) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    sum_d   = '0;
                    count_d = '0;
                    sat_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready   = (state_q != HOLD);
        out_valid  = (state_q == HOLD);
        data       = sum_q;
        norm_count = count_q;
        sat        = sat_q;
        state_dbg  = state_q;
    end

endmodule

// File: tb/tb_sample_accumulator.sv
// Bench for sample_accumulator: three instances (WINDOW 4, 2, 1) driven by directed
// scenarios and random traffic, each checked against a window-level reference model.
module tb_sample_accumulator;

    localparam int N = 3;

    function automatic int win_of(input int g);
        case (g)
            0:       return 4;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic               sv   [N];
    logic signed [31:0] smp  [N];
    logic               fl   [N];
    logic               ord  [N];
    logic               irdy [N];
    logic signed [31:0] dat  [N];
    logic        [15:0] ncnt [N];
    logic               ov   [N];
    logic               st   [N];
    logic        [1:0]  sdbg [N];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input int lane, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s lane%0d: got %0d expected %0d at %0t", name, lane, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < N; g++) begin : lane
        logic [48:0] exp_q[$];
        logic [48:0] cur = '0;
        longint      acc = 0;
        int          n = 0;
        bit          msat = 1'b0;
        bit          pending = 1'b0;
        bit          was_valid = 1'b0;

        sample_accumulator #(.WINDOW(win_of(g))) dut (
            .clk          (clk),
            .rst          (rst),
            .sample_valid (sv[g]),
            .sample       (smp[g]),
            .in_ready     (irdy[g]),
            .flush        (fl[g]),
            .data         (dat[g]),
            .norm_count   (ncnt[g]),
            .out_valid    (ov[g]),
            .out_ready    (ord[g]),
            .sat          (st[g]),
            .state_dbg    (sdbg[g])
        );

        // Reference: open window is a running saturating sum; a closed window is queued.
        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                exp_q.delete();
                acc = 0;
                n = 0;
                msat = 1'b0;
                pending = 1'b0;
            end else if (pending) begin
                if (ord[g]) pending = 1'b0;
            end else begin
                if (sv[g]) begin
                    acc = acc + longint'(smp[g]);
                    n++;
                    if (acc > 64'sd2147483647) begin
                        acc = 64'sd2147483647;
                        msat = 1'b1;
                    end else if (acc < -64'sd2147483648) begin
                        acc = -64'sd2147483648;
                        msat = 1'b1;
                    end
                end
                if ((n == win_of(g)) || (fl[g] && n > 0)) begin
                    exp_q.push_back({acc[31:0], 16'(n), msat});
                    acc = 0;
                    n = 0;
                    msat = 1'b0;
                    pending = 1'b1;
                end
            end
        end

        always @(negedge clk) begin
            if (!rst) begin
                check("rst_data", g, dat[g], 0);
                check("rst_count", g, ncnt[g], 0);
                check("rst_valid", g, ov[g], 0);
                check("rst_sat", g, st[g], 0);
                check("rst_in_ready", g, irdy[g], 1);
                was_valid = 1'b0;
            end else begin
                check("in_ready", g, irdy[g], !pending);
                check("out_valid", g, ov[g], pending);
                if (ov[g]) begin
                    if (!was_valid) begin
                        if (exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_window lane%0d: got data %0d expected none", g, dat[g]);
                        end else begin
                            cur = exp_q.pop_front();
                        end
                    end
                    check("data", g, dat[g], longint'($signed(cur[48:17])));
                    check("norm_count", g, ncnt[g], longint'(cur[16:1]));
                    check("sat", g, st[g], longint'(cur[0]));
                end
                was_valid = ov[g];
            end
        end
    end

    task automatic idle_all();
        for (int i = 0; i < N; i++) begin
            sv[i] = 1'b0;
            smp[i] = '0;
            fl[i] = 1'b0;
            ord[i] = 1'b1;
        end
    endtask

    task automatic drive(input int l, input bit v, input int s, input bit f, input bit r);
        idle_all();
        sv[l] = v;
        smp[l] = s;
        fl[l] = f;
        ord[l] = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int k);
        idle_all();
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        idle_all();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        // back-to-back full window on WINDOW=4
        drive(0, 1, 10, 0, 1);
        drive(0, 1, 20, 0, 1);
        drive(0, 1, 30, 0, 1);
        drive(0, 1, 40, 0, 1);
        idle_cycles(3);

        // early close with a same-cycle sample
        drive(0, 1, 5, 0, 1);
        drive(0, 1, -7, 0, 1);
        drive(0, 1, 2, 1, 1);
        idle_cycles(3);

        // saturation on WINDOW=2, then a clean window
        drive(1, 1, 2147483647, 0, 1);
        drive(1, 1, 5, 0, 1);
        idle_cycles(2);
        drive(1, 1, 1, 0, 1);
        drive(1, 1, 1, 0, 1);
        idle_cycles(2);

        // back-pressure: window held, samples ignored, then released
        drive(0, 1, 1, 0, 0);
        drive(0, 1, 2, 0, 0);
        drive(0, 1, 3, 0, 0);
        drive(0, 1, 4, 0, 0);
        repeat (5) drive(0, 1, 99, 0, 0);
        drive(0, 0, 0, 0, 1);
        drive(0, 1, 7, 0, 1);
        drive(0, 1, 7, 0, 1);
        drive(0, 1, 7, 0, 1);
        drive(0, 1, 7, 0, 1);
        idle_cycles(3);

        // bare flush in IDLE, then WINDOW=1
        drive(2, 0, 0, 1, 1);
        drive(0, 0, 0, 1, 1);
        idle_cycles(2);
        drive(2, 1, 9, 0, 1);
        idle_cycles(2);

        // reset mid-window discards the partial sum
        drive(0, 1, 100, 0, 1);
        drive(0, 1, 200, 0, 1);
        idle_all();
        rst = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        drive(0, 1, 1, 0, 1);
        drive(0, 1, 2, 0, 1);
        drive(0, 1, 3, 0, 1);
        drive(0, 1, 4, 0, 1);
        idle_cycles(3);

        // random traffic on all lanes
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                sv[i] = ($urandom_range(0, 9) < 7);
                if ($urandom_range(0, 3) == 0) smp[i] = $urandom();
                else smp[i] = int'($urandom_range(0, 400)) - 200;
                fl[i] = ($urandom_range(0, 9) == 0);
                ord[i] = ($urandom_range(0, 9) < 7);
            end
            @(posedge clk);
            #1;
        end

        idle_cycles(5);
        check("drain", 0, lane[0].exp_q.size(), 0);
        check("drain", 1, lane[1].exp_q.size(), 0);
        check("drain", 2, lane[2].exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
